// File: rtl/dcache_dm_if.sv
// Datapath and memory-side signal bundle for the direct-mapped data cache.
// slave  : the cache (takes datapath requests and halt, drives the memory request).
// master : the environment (datapath plus memory arbiter) facing the cache.
interface dcache_dm_if;
  // datapath request / response
  logic        dmemREN;
  logic        dmemWEN;
  logic        datomic;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        halt;
  logic        dhit;
  logic [31:0] dmemload;
  logic        flushed;
  // memory arbiter side
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;

  modport slave (
    input  dmemREN, dmemWEN, datomic, dmemaddr, dmemstore, halt, dwait, dload,
    output dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );

  modport master (
    output dmemREN, dmemWEN, datomic, dmemaddr, dmemstore, halt, dwait, dload,
    input  dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );
endinterface

// File: rtl/dcache_dm.sv
// Direct-mapped write-back write-allocate L1 data cache with a single LL/SC link and halt-time flush.
// Latency: hit and failed SC complete combinationally; clean miss = 2 memory transfers + 1 cycle, dirty miss adds 2 write transfers.
// Backpressure: memory dwait stalls WB/FETCH/FLUSH states; the datapath holds its request until dhit.
// Ports: CLK, nRST (async active-low) plus the slave side of dcache_dm_if
//   (datapath: dmemREN/dmemWEN/datomic/dmemaddr/dmemstore/halt -> dhit/dmemload/flushed;
//    memory:   dREN/dWEN/daddr/dstore <- dwait/dload).
module dcache_dm #(
  parameter int SETS = 16
) (
  input  logic       CLK,
  input  logic       nRST,
  dcache_dm_if.slave bus
);
  localparam int IDXW = $clog2(SETS);
  localparam int TAGW = 32 - 3 - IDXW;

  typedef enum logic [2:0] {
    IDLE, WB0, WB1, FETCH0, FETCH1, FLUSH0, FLUSH1, FLUSHED
  } state_t;

  state_t state, state_nx;

  // storage: tag/data arrays are never reset, valid/dirty are
  logic [TAGW-1:0] tag_arr   [SETS];
  logic [31:0]     word0_arr [SETS];
  logic [31:0]     word1_arr [SETS];
  logic [SETS-1:0] valid;
  logic [SETS-1:0] dirty;

  logic [31:0]     link_addr;
  logic            link_valid;
  logic [IDXW-1:0] cnt;

  // request decode
  logic [IDXW-1:0] idx;
  logic [TAGW-1:0] req_tag;
  logic            blk;
  logic            req;
  logic            is_wr;
  logic            is_sc;
  logic            is_ll;
  logic            sc_ok;
  logic            sc_fail;
  logic            hit;
  logic            victim_dirty;
  logic [31:0]     hit_word;
  logic            flush_dirty;
  logic            last_set;

  // control strobes from the next-state process
  logic wr_hit;
  logic ll_hit;
  logic fill0;
  logic fill1;
  logic fill_done;
  logic flush_clr;
  logic cnt_inc;
  logic cnt_clr;

  assign idx      = bus.dmemaddr[3 +: IDXW];
  assign req_tag  = bus.dmemaddr[31 -: TAGW];
  assign blk      = bus.dmemaddr[2];
  assign req      = bus.dmemREN | bus.dmemWEN;
  // a request with both enables is a write
  assign is_wr    = bus.dmemWEN;
  assign is_sc    = bus.dmemWEN & bus.datomic;
  assign is_ll    = bus.dmemREN & ~bus.dmemWEN & bus.datomic;
  // full-address compare keeps the link word-granular
  assign sc_ok    = link_valid && (link_addr == bus.dmemaddr);
  assign sc_fail  = is_sc & ~sc_ok;
  assign hit      = valid[idx] && (tag_arr[idx] == req_tag);
  assign victim_dirty = valid[idx] & dirty[idx];
  assign hit_word = blk ? word1_arr[idx] : word0_arr[idx];
  assign flush_dirty  = valid[cnt] & dirty[cnt];
  assign last_set = (cnt == IDXW'(SETS - 1));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    bus.dhit     = 1'b0;
    bus.dmemload = 32'd0;
    bus.flushed  = 1'b0;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.daddr    = 32'd0;
    bus.dstore   = 32'd0;
    wr_hit       = 1'b0;
    ll_hit       = 1'b0;
    fill0        = 1'b0;
    fill1        = 1'b0;
    fill_done    = 1'b0;
    flush_clr    = 1'b0;
    cnt_inc      = 1'b0;
    cnt_clr      = 1'b0;

    case (state)
      IDLE: begin
        if (bus.halt) begin
          // halt wins over any pending request
          state_nx = FLUSH0;
          cnt_clr  = 1'b1;
        end else if (sc_fail) begin
          // failed SC answers at once with 0 and touches nothing
          bus.dhit = 1'b1;
        end else if (req) begin
          if (hit) begin
            bus.dhit = 1'b1;
            if (is_wr) begin
              wr_hit       = 1'b1;
              bus.dmemload = is_sc ? 32'd1 : hit_word;
            end else begin
              ll_hit       = is_ll;
              bus.dmemload = hit_word;
            end
          end else begin
            state_nx = victim_dirty ? WB0 : FETCH0;
          end
        end
      end

      WB0: begin
        bus.dWEN   = 1'b1;
        bus.daddr  = {tag_arr[idx], idx, 1'b0, 2'b00};
        bus.dstore = word0_arr[idx];
        if (!bus.dwait) state_nx = WB1;
      end

      WB1: begin
        bus.dWEN   = 1'b1;
        bus.daddr  = {tag_arr[idx], idx, 1'b1, 2'b00};
        bus.dstore = word1_arr[idx];
        if (!bus.dwait) state_nx = FETCH0;
      end

      FETCH0: begin
        bus.dREN  = 1'b1;
        bus.daddr = {req_tag, idx, 1'b0, 2'b00};
        if (!bus.dwait) begin
          fill0    = 1'b1;
          state_nx = FETCH1;
        end
      end

      FETCH1: begin
        bus.dREN  = 1'b1;
        bus.daddr = {req_tag, idx, 1'b1, 2'b00};
        if (!bus.dwait) begin
          fill1     = 1'b1;
          fill_done = 1'b1;
          state_nx  = IDLE;
        end
      end

      FLUSH0: begin
        if (flush_dirty) begin
          bus.dWEN   = 1'b1;
          bus.daddr  = {tag_arr[cnt], cnt, 1'b0, 2'b00};
          bus.dstore = word0_arr[cnt];
          if (!bus.dwait) state_nx = FLUSH1;
        end else begin
          // nothing to write back for this set: move on in one cycle
          flush_clr = 1'b1;
          cnt_inc   = 1'b1;
          state_nx  = last_set ? FLUSHED : FLUSH0;
        end
      end

      FLUSH1: begin
        bus.dWEN   = 1'b1;
        bus.daddr  = {tag_arr[cnt], cnt, 1'b1, 2'b00};
        bus.dstore = word1_arr[cnt];
        if (!bus.dwait) begin
          flush_clr = 1'b1;
          cnt_inc   = 1'b1;
          state_nx  = last_set ? FLUSHED : FLUSH0;
        end
      end

      FLUSHED: begin
        bus.flushed = 1'b1;
      end

      default: state_nx = IDLE;
    endcase
  end

  // valid/dirty, link register and flush counter
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid      <= '0;
      dirty      <= '0;
      link_addr  <= 32'd0;
      link_valid <= 1'b0;
      cnt        <= '0;
    end else begin
      if (wr_hit) begin
        dirty[idx] <= 1'b1;
        // successful SC consumes the link; any store to the linked word breaks it
        if (is_sc || (bus.dmemaddr == link_addr)) link_valid <= 1'b0;
      end
      if (ll_hit) begin
        link_addr  <= bus.dmemaddr;
        link_valid <= 1'b1;
      end
      if (fill_done) begin
        valid[idx] <= 1'b1;
        dirty[idx] <= 1'b0;
      end
      if (flush_clr) dirty[cnt] <= 1'b0;
      if (cnt_clr) begin
        cnt <= '0;
      end else if (cnt_inc) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // tag and data arrays
  always_ff @(posedge CLK) begin
    if (wr_hit) begin
      if (blk) begin
        word1_arr[idx] <= bus.dmemstore;
      end else begin
        word0_arr[idx] <= bus.dmemstore;
      end
    end
    if (fill0) word0_arr[idx] <= bus.dload;
    if (fill1) word1_arr[idx] <= bus.dload;
    if (fill_done) tag_arr[idx] <= req_tag;
  end
endmodule
